mem_stream_tx: RTL and testbench

Transmit side of the 16-bit memory stream carried in the `mem_data_b16` field of the GBT frame. It holds `g_pages` 32-bit configuration words (switch configuration per motor) in a local register file written by the host logic. It continuously broadcasts those words, round-robin, as framed 16-bit words, one word per GBT frame clock. The block sits on the VFC/test-bench side of the link and feeds the page receiver that drives the front-panel extremity-switch LEDs.

---
 rtl/MCPkg.sv | 32 +++
 rtl/mem_stream_tx.sv | 180 ++++++++++++++++++
 tb/tb_mem_stream_tx.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/MCPkg.sv
// Shared definitions for the 16-bit memory stream carried in mem_data_b16.
// Used by both the transmitter (mem_stream_tx) and the page receiver.
package MCPkg;

    // First byte of every frame header; the low byte carries the page index.
    localparam logic [7:0]  MEM_STREAM_HEADER = 8'hA5;

    // Word driven on the stream whenever no frame word is being sent.
    localparam logic [15:0] MEM_STREAM_IDLE   = 16'h0000;

    // Frame sequencer states. MS_CSUM is only visited in checksum builds.
    typedef enum logic [2:0] {
        MS_IDLE = 3'd0,
        MS_HDR  = 3'd1,
        MS_HI   = 3'd2,
        MS_LO   = 3'd3,
        MS_CSUM = 3'd4,
        MS_GAP  = 3'd5
    } memstreamstate_t;

    // Clock/reset bundle. The reset is asynchronous and active-high.
    typedef struct packed {
        logic clk;
        logic reset;
    } t_clk_rs;

    // Header word for a given page.
    function automatic logic [15:0] mem_stream_hdr(input logic [7:0] page);
        return {MEM_STREAM_HEADER, page};
    endfunction

endpackage

// File: rtl/mem_stream_tx.sv
// Memory stream transmitter: holds g_pages 32-bit configuration words and
// broadcasts them round-robin as framed 16-bit words (HDR, HI, LO[, CSUM]),
// followed by g_gapWords idle words per frame.
// Build option: define MEM_STREAM_TX_CHECKSUM_EN to append the CSUM word
// (HDR ^ HI ^ LO) to every frame. The receiver must use the same setting.
module mem_stream_tx
    import MCPkg::*;
#(
    parameter int g_pages    = 16,
    parameter int g_gapWords = 0
) (
    input  t_clk_rs      ClkRs_ix,
    input  logic         enable_i,
    input  logic         wr_i,
    input  logic [7:0]   wraddr_ib8,
    input  logic [31:0]  data_ib32,
    output logic [15:0]  data_ob16,
    output logic         sof_o,
    output logic         cycle_o,
    output logic         busy_o
);

    // Register file is rounded up to a power of two so the page pointer can
    // index it directly; entries at or above g_pages are never written.
    localparam int         PAGE_AW   = (g_pages > 1) ? $clog2(g_pages) : 1;
    localparam int         RF_DEPTH  = 2 ** PAGE_AW;
    localparam logic [7:0] LAST_PAGE = 8'(g_pages - 1);
    localparam bit         HAS_GAP   = (g_gapWords > 0);
    localparam logic [3:0] GAP_LAST  = HAS_GAP ? 4'(g_gapWords - 1) : 4'd0;

    logic clk;
    logic rst;

    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    memstreamstate_t state_q,   state_d;
    logic [7:0]      page_q,    page_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;
    logic [31:0]     snap_q,    snap_d;
    logic [31:0]     rf_q [RF_DEPTH];
    logic [31:0]     rf_d [RF_DEPTH];
    logic [15:0]     data_q,    data_d;
    logic            sof_q,     sof_d;
    logic            cycle_q,   cycle_d;
    logic            busy_q,    busy_d;
    logic            frame_end;

    // Host writes into the page register file; out-of-range indices are dropped.
    always_comb begin
        rf_d = rf_q;
        if (wr_i && (int'(wraddr_ib8) < g_pages)) begin
            rf_d[wraddr_ib8[PAGE_AW-1:0]] = data_ib32;
        end
    end

    // Frame sequencing: next state, snapshot capture, page pointer and gap count.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        gap_cnt_d = gap_cnt_q;
        snap_d    = snap_q;
        frame_end = 1'b0;

        case (state_q)
            MS_IDLE: begin
                if (enable_i) begin
                    state_d = MS_HDR;
                end
            end
            MS_HDR: begin
                // The snapshot reads the stored word before any write landing
                // in this same cycle, so the frame stays self-consistent.
                snap_d  = rf_q[page_q[PAGE_AW-1:0]];
                state_d = MS_HI;
            end
            MS_HI: begin
                state_d = MS_LO;
            end
`ifdef MEM_STREAM_TX_CHECKSUM_EN
            MS_LO: begin
                state_d = MS_CSUM;
            end
            MS_CSUM: begin
                frame_end = 1'b1;
            end
`else
            MS_LO: begin
                frame_end = 1'b1;
            end
`endif
            MS_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 4'd0;
                    state_d   = enable_i ? MS_HDR : MS_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase

        // Last word of a frame: advance the page and pick gap, next frame or idle.
        if (frame_end) begin
            page_d = (page_q == LAST_PAGE) ? 8'd0 : page_q + 8'd1;
            if (HAS_GAP) begin
                state_d   = MS_GAP;
                gap_cnt_d = 4'd0;
            end else begin
                state_d = enable_i ? MS_HDR : MS_IDLE;
            end
        end
    end

    // Stream word and flags for the current state, registered one cycle later.
    always_comb begin
        data_d  = MEM_STREAM_IDLE;
        sof_d   = 1'b0;
        busy_d  = 1'b0;
        cycle_d = frame_end && (page_q == LAST_PAGE);

        case (state_q)
            MS_HDR: begin
                data_d = mem_stream_hdr(page_q);
                sof_d  = 1'b1;
                busy_d = 1'b1;
            end
            MS_HI: begin
                data_d = snap_q[31:16];
                busy_d = 1'b1;
            end
            MS_LO: begin
                data_d = snap_q[15:0];
                busy_d = 1'b1;
            end
`ifdef MEM_STREAM_TX_CHECKSUM_EN
            MS_CSUM: begin
                data_d = mem_stream_hdr(page_q) ^ snap_q[31:16] ^ snap_q[15:0];
                busy_d = 1'b1;
            end
`endif
            default: begin
                data_d = MEM_STREAM_IDLE;
            end
        endcase
    end

    // All state and registered outputs; reset clears everything including pages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MS_IDLE;
            page_q    <= 8'd0;
            gap_cnt_q <= 4'd0;
            snap_q    <= 32'h0;
            rf_q      <= '{default: 32'h0};
            data_q    <= MEM_STREAM_IDLE;
            sof_q     <= 1'b0;
            cycle_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            gap_cnt_q <= gap_cnt_d;
            snap_q    <= snap_d;
            rf_q      <= rf_d;
            data_q    <= data_d;
            sof_q     <= sof_d;
            cycle_q   <= cycle_d;
            busy_q    <= busy_d;
        end
    end

    assign data_ob16 = data_q;
    assign sof_o     = sof_q;
    assign cycle_o   = cycle_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_mem_stream_tx.sv
// Bench for mem_stream_tx: two instances (4 pages, gap 0 and gap 2) share the
// same inputs. A queue-based stream model predicts every output word.
module tb_mem_stream_tx;
    import MCPkg::*;

    localparam int P = 4;
`ifdef MEM_STREAM_TX_CHECKSUM_EN
    localparam int CSUM_ON = 1;
`else
    localparam int CSUM_ON = 0;
`endif
    localparam int L = 3 + CSUM_ON;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        cyc;
        logic        busy;
    } ent_t;

    typedef struct {
        logic        en;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [15:0] e_data;
        logic        e_sof;
        logic        e_cyc;
        logic        e_busy;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    t_clk_rs     clk_rs;

    assign clk_rs = '{clk: clk, reset: rst};
    always #5 clk = ~clk;

    logic [15:0] d0, d1;
    logic        s0, s1, c0, c1, b0, b1;

    mem_stream_tx #(.g_pages(P), .g_gapWords(0)) u_dut0 (
        .ClkRs_ix(clk_rs), .enable_i(en), .wr_i(wr), .wraddr_ib8(addr),
        .data_ib32(wdata), .data_ob16(d0), .sof_o(s0), .cycle_o(c0), .busy_o(b0)
    );

    mem_stream_tx #(.g_pages(P), .g_gapWords(2)) u_dut1 (
        .ClkRs_ix(clk_rs), .enable_i(en), .wr_i(wr), .wraddr_ib8(addr),
        .data_ib32(wdata), .data_ob16(d1), .sof_o(s1), .cycle_o(c1), .busy_o(b1)
    );

    // ---------------- scoreboard / model ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    ent_t        exp_q [2][$];
    ent_t        exp_cur [2];
    int          gap_m [2];
    int          ptr_m [2];
    logic [31:0] mem_m [P];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [15:0] dat, input logic sof, input logic cyc, input logic busy);
        ent_t e;
        e.data = dat; e.sof = sof; e.cyc = cyc; e.busy = busy;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            ptr_m[i] = 0;
        end
        for (int p = 0; p < P; p++) mem_m[p] = 32'h0;
    endtask

    // Queue the whole frame plus its trailing idle words for instance i.
    task automatic push_frame(input int i);
        logic [15:0] h, hi, lo;
        logic        last;
        h    = {MEM_STREAM_HEADER, 8'(ptr_m[i])};
        hi   = mem_m[ptr_m[i]][31:16];
        lo   = mem_m[ptr_m[i]][15:0];
        last = (ptr_m[i] == P - 1);
        exp_q[i].push_back(mk(h, 1'b1, 1'b0, 1'b1));
        exp_q[i].push_back(mk(hi, 1'b0, 1'b0, 1'b1));
        exp_q[i].push_back(mk(lo, 1'b0, last && (CSUM_ON == 0), 1'b1));
        if (CSUM_ON != 0) exp_q[i].push_back(mk(h ^ hi ^ lo, 1'b0, last, 1'b1));
        for (int g = 0; g < gap_m[i]; g++) exp_q[i].push_back(mk(16'h0, 1'b0, 1'b0, 1'b0));
        ptr_m[i] = (ptr_m[i] + 1) % P;
    endtask

    // One clock edge of the model: emit queued word, apply write, start frames.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst && exp_q[i].size() > 0) exp_cur[i] = exp_q[i].pop_front();
            else                             exp_cur[i] = mk(16'h0, 1'b0, 1'b0, 1'b0);
        end
        if (rst) begin
            model_reset();
        end else begin
            if (wr && int'(addr) < P) mem_m[addr] = wdata;
            for (int i = 0; i < 2; i++) begin
                if (exp_q[i].size() == 0 && en) push_frame(i);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("dut0_data", d0, exp_cur[0].data);
        chk("dut0_sof",  s0, exp_cur[0].sof);
        chk("dut0_cyc",  c0, exp_cur[0].cyc);
        chk("dut0_busy", b0, exp_cur[0].busy);
        chk("dut1_data", d1, exp_cur[1].data);
        chk("dut1_sof",  s1, exp_cur[1].sof);
        chk("dut1_cyc",  c1, exp_cur[1].cyc);
        chk("dut1_busy", b1, exp_cur[1].busy);
    endtask

    task automatic wait_hdr(input int dut, input bit any_page, input logic [7:0] pg, input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            tick();
            if (dut == 0) ok = s0 && (any_page || d0 == {MEM_STREAM_HEADER, pg});
            else          ok = s1 && (any_page || d1 == {MEM_STREAM_HEADER, pg});
        end
        chk("wait_hdr", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        vec_t vt [7];
        gap_m[0] = 0;
        gap_m[1] = 2;
        en = 1'b0; wr = 1'b0; addr = 8'd0; wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data0", d0, 16'h0);
        chk("rst_sof0",  s0, 1'b0);
        chk("rst_cyc0",  c0, 1'b0);
        chk("rst_busy0", b0, 1'b0);
        chk("rst_data1", d1, 16'h0);
        rst = 1'b0;

        // Table: write page 0, one-cycle enable, frame for page 0 then idle.
        vt[0] = '{en:1'b0, wr:1'b1, addr:8'd0, wdata:32'h12345678, e_data:16'h0000, e_sof:1'b0, e_cyc:1'b0, e_busy:1'b0};
        vt[1] = '{en:1'b1, wr:1'b0, addr:8'd0, wdata:32'h0, e_data:16'h0000, e_sof:1'b0, e_cyc:1'b0, e_busy:1'b0};
        vt[2] = '{en:1'b0, wr:1'b0, addr:8'd0, wdata:32'h0, e_data:16'hA500, e_sof:1'b1, e_cyc:1'b0, e_busy:1'b1};
        vt[3] = '{en:1'b0, wr:1'b0, addr:8'd0, wdata:32'h0, e_data:16'h1234, e_sof:1'b0, e_cyc:1'b0, e_busy:1'b1};
        vt[4] = '{en:1'b0, wr:1'b0, addr:8'd0, wdata:32'h0, e_data:16'h5678, e_sof:1'b0, e_cyc:1'b0, e_busy:1'b1};
        vt[5] = '{en:1'b0, wr:1'b0, addr:8'd0, wdata:32'h0, e_data:(CSUM_ON != 0) ? 16'hE14C : 16'h0000,
                  e_sof:1'b0, e_cyc:1'b0, e_busy:(CSUM_ON != 0)};
        vt[6] = '{en:1'b0, wr:1'b0, addr:8'd0, wdata:32'h0, e_data:16'h0000, e_sof:1'b0, e_cyc:1'b0, e_busy:1'b0};
        for (int k = 0; k < 7; k++) begin
            en = vt[k].en; wr = vt[k].wr; addr = vt[k].addr; wdata = vt[k].wdata;
            tick();
            chk("tbl_data", d0, vt[k].e_data);
            chk("tbl_sof",  s0, vt[k].e_sof);
            chk("tbl_cyc",  c0, vt[k].e_cyc);
            chk("tbl_busy", b0, vt[k].e_busy);
        end
        wr = 1'b0;

        // Page 3 = DEADBEEF: check HI/LO/CSUM and the wrap pulse.
        wr = 1'b1; addr = 8'd3; wdata = 32'hDEADBEEF; en = 1'b1;
        tick();
        wr = 1'b0;
        wait_hdr(0, 1'b0, 8'h03, 40);
        tick();
        chk("p3_hi", d0, 16'hDEAD);
        tick();
        chk("p3_lo", d0, 16'hBEEF);
        chk("p3_lo_cycle", c0, (CSUM_ON != 0) ? 1'b0 : 1'b1);
`ifdef MEM_STREAM_TX_CHECKSUM_EN
        tick();
        chk("p3_csum", d0, 16'hC541);
        chk("p3_csum_cycle", c0, 1'b1);
`endif

        // Gap of two idle words between frames on the gap-2 instance.
        wait_hdr(1, 1'b1, 8'h00, 40);
        repeat (L - 1) tick();
        tick();
        chk("gap_w0_data", d1, 16'h0);
        chk("gap_w0_busy", b1, 1'b0);
        tick();
        chk("gap_w1_data", d1, 16'h0);
        tick();
        chk("gap_next_sof", s1, 1'b1);

        // Write page 1 while its header is on the stream.
        wr = 1'b1; addr = 8'd1; wdata = 32'h11112222;
        tick();
        wr = 1'b0;
        wait_hdr(0, 1'b0, 8'h01, 40);
        wr = 1'b1; addr = 8'd1; wdata = 32'h33334444;
        tick();
        wr = 1'b0;
        chk("hdrwr_old_hi", d0, 16'h1111);
        tick();
        chk("hdrwr_old_lo", d0, 16'h2222);
        wait_hdr(0, 1'b0, 8'h01, 40);
        tick();
        chk("hdrwr_new_hi", d0, 16'h3333);
        tick();
        chk("hdrwr_new_lo", d0, 16'h4444);

        // Drop enable during HI: frame completes, then idle.
        wait_hdr(0, 1'b1, 8'h00, 40);
        tick();
        en = 1'b0;
        tick();
        chk("endrop_lo_busy", b0, 1'b1);
`ifdef MEM_STREAM_TX_CHECKSUM_EN
        tick();
        chk("endrop_csum_busy", b0, 1'b1);
`endif
        tick();
        chk("endrop_idle_data", d0, 16'h0);
        chk("endrop_idle_busy", b0, 1'b0);
        repeat (8) tick();
        chk("endrop_hold_data", d0, 16'h0);
        chk("endrop_hold_sof", s0, 1'b0);

        // Reset asserted during LO.
        en = 1'b1;
        wait_hdr(0, 1'b1, 8'h00, 40);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_data0", d0, 16'h0);
        chk("arst_busy0", b0, 1'b0);
        chk("arst_sof0",  s0, 1'b0);
        chk("arst_data1", d1, 16'h0);
        chk("arst_busy1", b1, 1'b0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_idle", d0, 16'h0);
        tick();
        chk("postrst_hdr", d0, 16'hA500);
        chk("postrst_sof", s0, 1'b1);

        // Load all pages, then write out-of-range indices; refresh must be unchanged.
        for (int p = 0; p < P; p++) begin
            wr = 1'b1; addr = 8'(p); wdata = $urandom;
            tick();
        end
        wr = 1'b1; addr = 8'(P); wdata = 32'hBAD0BAD0;
        tick();
        addr = 8'hFF; wdata = 32'hBAD1BAD1;
        tick();
        addr = 8'(P + 128); wdata = 32'hBAD2BAD2;
        tick();
        wr = 1'b0;
        repeat (2 * P * (L + 2) + 4) tick();

        // Randomized enable and writes, model checks every word.
        for (int k = 0; k < 400; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            wr    = ($urandom_range(0, 3) == 0);
            addr  = 8'($urandom_range(0, P + 1));
            wdata = $urandom;
            tick();
        end
        wr = 1'b0;
        en = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
